// File: rtl/dm_port_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory.
// Master 0 has fixed priority; a wait counter promotes master 1 after MAX_WAIT lost decisions.
module dm_port_arbiter #(
  parameter int unsigned           ARCH_WIDTH   = 32,
  parameter int unsigned           DM_WIDTH     = 32,
  parameter int unsigned           DMBE_WIDTH   = 4,
  parameter logic [ARCH_WIDTH-1:0] DM_ADDR_BASE = 'h3000,
  parameter int unsigned           DM_SIZE      = 1024,
  parameter int unsigned           MAX_WAIT     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_wr,
  input  logic [ARCH_WIDTH-1:0]   m0_addr,
  input  logic [0:DMBE_WIDTH-1]   m0_be,
  input  logic [0:DM_WIDTH-1]     m0_wdata,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic [0:DM_WIDTH-1]     m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_wr,
  input  logic [ARCH_WIDTH-1:0]   m1_addr,
  input  logic [0:DMBE_WIDTH-1]   m1_be,
  input  logic [0:DM_WIDTH-1]     m1_wdata,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [0:DM_WIDTH-1]     m1_rdata,
  output logic                    dm_wr,
  output logic [0:DMBE_WIDTH-1]   dm_be,
  output logic [ARCH_WIDTH-1:0]   dm_addr,
  output logic [0:DM_WIDTH-1]     dm_din,
  input  logic [0:DM_WIDTH-1]     dm_dout,
  output logic [1:0]              owner,
  output logic [1:0]              dbg_state,
  output logic [3:0]              dbg_wait_cnt
);

  // Handshake: a master raises req with stable fields and holds them until its
  // one-cycle ack; req still high in the cycle after ack starts a new access.

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam int unsigned          AW1        = ARCH_WIDTH + 1;
  localparam logic [ARCH_WIDTH:0]  DM_LO      = {1'b0, DM_ADDR_BASE};
  localparam logic [ARCH_WIDTH:0]  DM_HI      = DM_LO + AW1'(4 * DM_SIZE);
  localparam logic [3:0]           MAX_WAIT_C = 4'(MAX_WAIT);

  state_t                  state, state_nxt;
  logic                    h_wr, h_err;
  logic [ARCH_WIDTH-1:0]   h_addr;
  logic [0:DMBE_WIDTH-1]   h_be;
  logic [0:DM_WIDTH-1]     h_wdata;
  logic [0:DM_WIDTH-1]     rd_reg;
  logic [3:0]              wait_cnt;

  logic                    any_req, grant_m1, addr_err;
  logic                    sel_wr;
  logic [ARCH_WIDTH-1:0]   sel_addr;
  logic [0:DMBE_WIDTH-1]   sel_be;
  logic [0:DM_WIDTH-1]     sel_wdata;

  assign any_req   = m0_req | m1_req;
  assign grant_m1  = m1_req & ((wait_cnt >= MAX_WAIT_C) | ~m0_req);
  assign sel_wr    = grant_m1 ? m1_wr    : m0_wr;
  assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
  assign sel_be    = grant_m1 ? m1_be    : m0_be;
  assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
  // Widened compare so BASE + 4*SIZE cannot wrap at the top of the address space.
  assign addr_err  = ({1'b0, sel_addr} < DM_LO) | ({1'b0, sel_addr} >= DM_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_wr     <= 1'b0;
      h_err    <= 1'b0;
      h_addr   <= '0;
      h_be     <= '0;
      h_wdata  <= '0;
      rd_reg   <= '0;
      owner    <= 2'b00;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          h_wr    <= sel_wr;
          h_addr  <= sel_addr;
          h_be    <= sel_be;
          h_wdata <= sel_wdata;
          h_err   <= addr_err;
          owner   <= grant_m1 ? 2'b10 : 2'b01;
          if (grant_m1)
            wait_cnt <= 4'd0;
          else if (m1_req && wait_cnt < MAX_WAIT_C)
            wait_cnt <= wait_cnt + 4'd1;
        end
        ACCESS: rd_reg <= (h_wr | h_err) ? '0 : dm_dout;
        RESP:   owner  <= 2'b00;
        default: ;
      endcase
    end
  end

  assign dm_wr        = (state == ACCESS) & h_wr & ~h_err;
  assign dm_be        = h_be;
  assign dm_addr      = h_addr;
  assign dm_din       = h_wdata;
  assign m0_ack       = (state == RESP) & (owner == 2'b01);
  assign m1_ack       = (state == RESP) & (owner == 2'b10);
  assign m0_err       = m0_ack & h_err;
  assign m1_err       = m1_ack & h_err;
  assign m0_rdata     = rd_reg;
  assign m1_rdata     = rd_reg;
  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: behavioural DM, request drivers, and an ack scoreboard
// holding {master, err, rdata} per expected completion.
module tb_dm_port_arbiter;

  localparam int W = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [0:3]  m0_be = '0;
  logic [0:31] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [0:3]  m1_be = '0;
  logic [0:31] m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err, dm_wr;
  logic [0:31] m0_rdata, m1_rdata, dm_din, dm_dout;
  logic [0:3]  dm_be;
  logic [31:0] dm_addr;
  logic [1:0]  owner, dbg_state;
  logic [3:0]  dbg_wait_cnt;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  dm_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_wr(dm_wr), .dm_be(dm_be), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
    .owner(owner), .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural DM: 1024 words at 0x3000, combinational read
  logic [0:31] mem [0:1023];
  logic [31:0] off;
  logic        in_rng;
  assign off     = dm_addr - 32'h3000;
  assign in_rng  = (dm_addr >= 32'h3000) && (dm_addr < 32'h4000);
  assign dm_dout = in_rng ? mem[off[11:2]] : '0;

  always @(posedge clk) begin
    if (dm_wr && in_rng)
      for (int i = 0; i < 4; i++)
        if (dm_be[i]) mem[off[11:2]][8*i +: 8] <= dm_din[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: pop one expectation per ack
  always @(negedge clk) begin
    if (rst) begin
      if (dm_wr) begin
        wr_pulses++;
        check("dm_wr_state", 32'(dbg_state), 32'd1);
      end
      if (m0_ack || m1_ack) begin
        check("ack_both", 32'(m0_ack & m1_ack), 32'd0);
        if (exp_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("ack_master", 32'(m1_ack), 32'(mon_e[33]));
          check("ack_err", 32'(m1_ack ? m1_err : m0_err), 32'(mon_e[32]));
          check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, mon_e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic m, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    if (!m) begin m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_be = be; m0_wdata = wdata; end
    else    begin m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_be = be; m1_wdata = wdata; end
  endtask

  task automatic wait_ack(input logic m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m ? m1_ack : m0_ack) && n < 20);
    if (n >= 20) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input logic m, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    drive(m, wr, addr, be, wdata);
    exp_q.push_back({m, exp_err, exp_rdata});
    wait_ack(m, n);
    check("ack_latency", 32'(n), 32'd2);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, acks, wp, t1, t2, t3;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h1122_3344;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_dm_wr", 32'(dm_wr), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("rst_wait", 32'(dbg_wait_cnt), 32'd0);
    rst = 1'b1;

    // master 0 read
    wp = wr_pulses;
    do_access(1'b0, 1'b0, 32'h3004, 4'b0000, 32'h0, 32'h1122_3344, 1'b0);
    check("read_no_wr", 32'(wr_pulses - wp), 32'd0);

    // master 1 byte-enabled write, then readback
    wp = wr_pulses;
    do_access(1'b1, 1'b1, 32'h3008, 4'b0011, 32'hAABB_CCDD, 32'h0, 1'b0);
    check("be_write_pulses", 32'(wr_pulses - wp), 32'd1);
    do_access(1'b1, 1'b0, 32'h3008, 4'b0000, 32'h0, 32'h1122_CCDD, 1'b0);

    // out-of-range write
    wp = wr_pulses;
    do_access(1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check("oor_no_wr", 32'(wr_pulses - wp), 32'd0);
    check("oor_dm_intact", mem[2], 32'h1122_CCDD);

    // starvation: both held high
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h3004, 4'b0000, 32'h0);
    drive(1'b1, 1'b0, 32'h3008, 4'b0000, 32'h0);
    for (int i = 0; i < 6; i++)
      exp_q.push_back((i == 4) ? {1'b1, 1'b0, 32'h1122_CCDD} : {1'b0, 1'b0, 32'h1122_3344});
    acks = 0;
    n = 0;
    while (acks < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if (m0_ack || m1_ack) begin
        acks++;
        if (acks == 4) check("starve_wait_sat", 32'(dbg_wait_cnt), 32'd4);
        if (acks == 5) check("starve_wait_clr", 32'(dbg_wait_cnt), 32'd0);
        if (acks == 6) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("starve_acks", 32'(acks), 32'd6);

    // reset during an m1 write's ACCESS cycle
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h300C, 4'b1111, 32'h5566_7788);
    @(negedge clk);
    check("mid_dm_wr_before", 32'(dm_wr), 32'd1);
    check("mid_owner_before", 32'(owner), 32'd2);
    rst = 1'b0;
    #1;
    check("mid_dm_wr_after", 32'(dm_wr), 32'd0);
    check("mid_owner_after", 32'(owner), 32'd0);
    check("mid_no_ack", 32'(m1_ack), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_no_ack_held", 32'(m1_ack), 32'd0);
    rst = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    wait_ack(1'b1, n);
    check("reissue_latency", 32'(n), 32'd2);
    m1_req = 1'b0;
    do_access(1'b1, 1'b0, 32'h300C, 4'b0000, 32'h0, 32'h5566_7788, 1'b0);

    // back-to-back master 1 reads, master 0 idle
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h3004, 4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b0, 32'h1122_3344});
    acks = 0; n = 0; t1 = 0; t2 = 0; t3 = 0;
    while (acks < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (m1_ack) begin
        acks++;
        check("b2b_wait", 32'(dbg_wait_cnt), 32'd0);
        if (acks == 1) t1 = n;
        if (acks == 2) t2 = n;
        if (acks == 3) begin t3 = n; m1_req = 1'b0; end
      end
    end
    m1_req = 1'b0;
    check("b2b_acks", 32'(acks), 32'd3);
    check("b2b_gap1", 32'(t2 - t1), 32'd3);
    check("b2b_gap2", 32'(t3 - t2), 32'd3);

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
